router_pkt_reader: RTL and testbench

Destination-side packet reader for the 1x3 router. It attaches to one router output port and drains the FIFO through `valid_out`, `read_enb` and `data_out`. It parses each packet (header, payload, parity), checks address and parity, and reports per-packet status. It is the consuming end of the same packet format the source side writes into the FIFO: header = {len[5:0], addr[1:0]}, then `len` payload bytes, then one parity byte.

---
 rtl/router_pkt_reader.sv | 208 ++++++++++++++++++++
 tb/tb_router_pkt_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_reader.sv
// router_pkt_reader
//
// Destination-side packet reader for the 1x3 router. It sits on one router
// output port, drains the FIFO and parses each packet:
//   header = {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte.
// The parity byte is the XOR of the header and every payload byte.
//
// Parameters:
//   PORT_ID    address served by this port; any other header addr, or 2'b11, is an addr error
//   READ_DELAY cycles valid_out must be high before the header read (0..28)
//   STALL_MAX  consecutive mid-packet cycles with valid_out low before the packet is aborted
//
// Ports:
//   clock, reset  single clock; synchronous active-high reset
//   valid_out     FIFO not-empty
//   data_out      FIFO read data, valid the cycle after read_enb
//   read_enb      FIFO read strobe (read request gated by valid_out and reset)
//   busy          FSM not in IDLE
//   pkt_done      one-cycle pulse at packet completion, with parity_err/addr_err
//   pkt_addr      header addr of the last packet (held)
//   pkt_len       header len of the last packet (held)
//   abort         one-cycle pulse when a stalled packet is dropped
//   pkt_count     completed packets
//   err_count     completed packets that had parity_err or addr_err
//
// Build option: define ROUTER_READER_STATS_EN to implement pkt_count/err_count.
// Without it both outputs are tied to 0 and no counter flops exist.

module router_pkt_reader #(
  parameter logic [1:0] PORT_ID    = 2'b00,
  parameter int         READ_DELAY = 2,
  parameter int         STALL_MAX  = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid_out,
  input  logic [7:0] data_out,
  output logic       read_enb,
  output logic       busy,
  output logic       pkt_done,
  output logic [1:0] pkt_addr,
  output logic [5:0] pkt_len,
  output logic       parity_err,
  output logic       addr_err,
  output logic       abort,
  output logic [7:0] pkt_count,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_HDR_RD,
    S_HDR_CAP,
    S_BODY,
    S_TAIL,
    S_DONE
  } state_t;

  localparam logic [4:0] DELAY_LAST = 5'(READ_DELAY);
  localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

  state_t     state;
  logic [4:0] delay_cnt;
  logic [7:0] stall_cnt;
  logic [6:0] remaining;
  logic [7:0] parity_acc;
  logic       byte_pend;
  logic       read_req;

  // Reads are only requested in HDR_RD and BODY; the strobe itself must never
  // fire on an empty FIFO or while reset is asserted.
  assign read_req = (state == S_HDR_RD) || (state == S_BODY);
  assign read_enb = read_req & valid_out & ~reset;
  assign busy     = (state != S_IDLE);

  // Main packet FSM. byte_pend marks that a non-final BODY read was issued on
  // the previous edge, so data_out now holds a payload byte to fold into the
  // parity accumulator. The final read of a packet is the parity byte, which is
  // compared in TAIL instead of being accumulated.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      delay_cnt  <= '0;
      stall_cnt  <= '0;
      remaining  <= '0;
      parity_acc <= '0;
      byte_pend  <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      abort      <= 1'b0;
      pkt_addr   <= '0;
      pkt_len    <= '0;
    end else begin
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      abort      <= 1'b0;
      byte_pend  <= 1'b0;

      case (state)
        S_IDLE: begin
          delay_cnt <= '0;
          stall_cnt <= '0;
          if (valid_out) begin
            if (READ_DELAY == 0) begin
              state <= S_HDR_RD;
            end else begin
              // The IDLE cycle that saw valid_out counts as the first delay cycle.
              state     <= S_DELAY;
              delay_cnt <= 5'd1;
            end
          end
        end

        S_DELAY: begin
          if (!valid_out) begin
            state     <= S_IDLE;
            delay_cnt <= '0;
          end else if (delay_cnt == DELAY_LAST) begin
            state <= S_HDR_RD;
          end else begin
            delay_cnt <= delay_cnt + 5'd1;
          end
        end

        S_HDR_RD: begin
          if (read_enb) begin
            state     <= S_HDR_CAP;
            stall_cnt <= '0;
          end else if (stall_cnt == STALL_LAST) begin
            abort <= 1'b1;
            state <= S_IDLE;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end

        S_HDR_CAP: begin
          pkt_len    <= data_out[7:2];
          pkt_addr   <= data_out[1:0];
          parity_acc <= data_out;
          remaining  <= {1'b0, data_out[7:2]} + 7'd1;
          stall_cnt  <= '0;
          state      <= S_BODY;
        end

        S_BODY: begin
          if (byte_pend) begin
            parity_acc <= parity_acc ^ data_out;
          end
          if (read_enb) begin
            stall_cnt <= '0;
            remaining <= remaining - 7'd1;
            if (remaining == 7'd1) begin
              state <= S_TAIL;
            end else begin
              byte_pend <= 1'b1;
            end
          end else if (stall_cnt == STALL_LAST) begin
            abort <= 1'b1;
            state <= S_IDLE;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end

        S_TAIL: begin
          // data_out is the received parity byte; flags are registered so they
          // line up with the pkt_done pulse in DONE.
          parity_err <= (parity_acc != data_out);
          addr_err   <= (pkt_addr != PORT_ID) || (pkt_addr == 2'b11);
          pkt_done   <= 1'b1;
          state      <= S_DONE;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ROUTER_READER_STATS_EN
  // Statistics counters advance during the DONE cycle, when the error flags of
  // the finished packet are on the outputs. Both wrap naturally at 8 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (state == S_DONE) begin
      pkt_count <= pkt_count + 8'd1;
      if (parity_err || addr_err) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`else
  assign pkt_count = 8'd0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_router_pkt_reader.sv
// Testbench for router_pkt_reader.
// A simple FIFO model feeds the reader; packets are built from random payload
// bytes and the expected status of each packet is computed from the packet
// format rules (length, XOR parity, address legality).

module tb_router_pkt_reader;

  localparam logic [1:0] PORT_ID    = 2'b01;
  localparam int         READ_DELAY = 2;
  localparam int         STALL_MAX  = 31;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       valid_out;
  logic [7:0] data_out = 8'd0;
  logic       read_enb;
  logic       busy;
  logic       pkt_done;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  logic       parity_err;
  logic       addr_err;
  logic       abort;
  logic [7:0] pkt_count;
  logic [7:0] err_count;

  router_pkt_reader #(
    .PORT_ID    (PORT_ID),
    .READ_DELAY (READ_DELAY),
    .STALL_MAX  (STALL_MAX)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .read_enb   (read_enb),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .pkt_addr   (pkt_addr),
    .pkt_len    (pkt_len),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .abort      (abort),
    .pkt_count  (pkt_count),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  // FIFO model: the initial block writes mem/wr_ptr, the FIFO process owns rd_ptr.
  logic [7:0] mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       flush  = 1'b0;

  assign valid_out = (wr_ptr != rd_ptr);

  always @(posedge clock) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (read_enb) begin
      data_out <= mem[rd_ptr[11:0]];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Monitor: sampled mid-cycle, records reads, completions and aborts.
  int         rd_cnt    = 0;
  int         done_cnt  = 0;
  int         abort_cnt = 0;
  int         bad_rd    = 0;
  logic [5:0] cap_len   = '0;
  logic [1:0] cap_addr  = '0;
  logic       cap_perr  = 1'b0;
  logic       cap_aerr  = 1'b0;

  always @(negedge clock) begin
    if (read_enb) rd_cnt <= rd_cnt + 1;
    if (read_enb && !valid_out) bad_rd <= bad_rd + 1;
    if (abort) abort_cnt <= abort_cnt + 1;
    if (pkt_done) begin
      done_cnt <= done_cnt + 1;
      cap_len  <= pkt_len;
      cap_addr <= pkt_addr;
      cap_perr <= parity_err;
      cap_aerr <= addr_err;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_pkt = 0;
  int exp_err = 0;
`ifdef ROUTER_READER_STATS_EN
  bit stats_on = 1'b1;
`else
  bit stats_on = 1'b0;
`endif

  function automatic logic [31:0] cnt_model(input int n);
    return stats_on ? 32'(n % 256) : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[11:0]] = b;
    wr_ptr++;
  endtask

  // Pushes a header, the first 'keep' payload bytes, and the parity byte if the
  // whole payload was pushed. Reports whether the sent parity is wrong.
  task automatic applyStimulus(input logic [7:0] hdr, input bit bad_par, input int keep,
                               output bit exp_perr);
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] sent;
    int len;
    len = int'(hdr[7:2]);
    x = hdr;
    push_byte(hdr);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      if (i < keep) push_byte(b);
    end
    sent = bad_par ? ~x : x;
    if (keep >= len) push_byte(sent);
    exp_perr = (sent != x);
  endtask

  // Sends one complete packet, waits for its pkt_done and checks it.
  task automatic run_packet(input logic [7:0] hdr, input bit bad_par, input bit detail,
                            input string tag);
    int d0, r0, k, lat;
    bit exp_perr, exp_aerr;
    d0 = done_cnt;
    r0 = rd_cnt;
    applyStimulus(hdr, bad_par, 64, exp_perr);
    exp_aerr = (hdr[1:0] != PORT_ID) || (hdr[1:0] == 2'b11);
    lat = -1;
    k = 0;
    while (done_cnt == d0 && k < 400) begin
      @(posedge clock); #1;
      k++;
      if (lat < 0 && read_enb) lat = k;
    end
    exp_pkt++;
    if (exp_perr || exp_aerr) exp_err++;
    checkOutput({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    if (detail) begin
      checkOutput({tag, "_lat"}, 32'(lat), 32'(READ_DELAY + 1));
      checkOutput({tag, "_reads"}, 32'(rd_cnt - r0), 32'(int'(hdr[7:2]) + 2));
      checkOutput({tag, "_len"}, 32'(cap_len), 32'(hdr[7:2]));
      checkOutput({tag, "_addr"}, 32'(cap_addr), 32'(hdr[1:0]));
      checkOutput({tag, "_perr"}, 32'(cap_perr), 32'(exp_perr));
      checkOutput({tag, "_aerr"}, 32'(cap_aerr), 32'(exp_aerr));
      checkOutput({tag, "_lenhold"}, 32'(pkt_len), 32'(hdr[7:2]));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_pktcnt"}, 32'(pkt_count), cnt_model(exp_pkt));
      checkOutput({tag, "_errcnt"}, 32'(err_count), cnt_model(exp_err));
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_read_enb"}, 32'(read_enb), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
    checkOutput({tag, "_perr"}, 32'(parity_err), 32'd0);
    checkOutput({tag, "_aerr"}, 32'(addr_err), 32'd0);
    checkOutput({tag, "_abort"}, 32'(abort), 32'd0);
    checkOutput({tag, "_addr"}, 32'(pkt_addr), 32'd0);
    checkOutput({tag, "_len"}, 32'(pkt_len), 32'd0);
    checkOutput({tag, "_pktcnt"}, 32'(pkt_count), 32'd0);
    checkOutput({tag, "_errcnt"}, 32'(err_count), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    flush = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
  endtask

  initial begin
    int d0, r0, a0, k, hdr_len;
    bit perr;
    logic [7:0] hdr;

    $display("[TB] router_pkt_reader bench start, stats_on=%0d", stats_on);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_values("rst");

    // Good packet: len 14, addr 01
    run_packet(8'h39, 1'b0, 1'b1, "good");

    // Same packet with inverted parity
    run_packet(8'h39, 1'b1, 1'b1, "badpar");

    // Wrong address, then the reserved address 11
    run_packet(8'h0A, 1'b0, 1'b1, "addr10");
    run_packet(8'h0B, 1'b0, 1'b1, "addr11");

    // Len-0 packet: only the parity byte is read in BODY
    run_packet(8'h01, 1'b0, 1'b1, "len0");

    // Random packets
    for (int i = 0; i < 10; i++) begin
      hdr = {6'($urandom_range(0, 20)), 2'($urandom_range(0, 3))};
      run_packet(hdr, 1'($urandom_range(0, 1)), 1'b1, "rand");
    end

    // Stall and abort: only header + 5 payload bytes ever arrive
    d0 = done_cnt;
    r0 = rd_cnt;
    a0 = abort_cnt;
    applyStimulus(8'h39, 1'b0, 5, perr);
    k = 0;
    while (!((rd_cnt - r0) == 6 && !valid_out) && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    checkOutput("stall_drain", 32'(rd_cnt - r0), 32'd6);
    k = 0;
    while (!abort && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    checkOutput("stall_cycles", 32'(k), 32'(STALL_MAX));
    checkOutput("stall_abort", 32'(abort), 32'd1);
    checkOutput("stall_busy", 32'(busy), 32'd0);
    checkOutput("stall_noread", 32'(rd_cnt - r0), 32'd6);
    checkOutput("stall_nodone", 32'(done_cnt - d0), 32'd0);
    checkOutput("stall_pktcnt", 32'(pkt_count), cnt_model(exp_pkt));
    checkOutput("stall_errcnt", 32'(err_count), cnt_model(exp_err));
    @(posedge clock); #1;
    checkOutput("stall_abort_pulse", 32'(abort), 32'd0);
    checkOutput("stall_abort_once", 32'(abort_cnt - a0), 32'd1);

    // Reset in the middle of BODY
    d0 = done_cnt;
    r0 = rd_cnt;
    applyStimulus(8'h29, 1'b0, 64, perr);
    k = 0;
    while ((rd_cnt - r0) < 4 && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    reset = 1'b1;
    flush = 1'b1;
    #2;
    checkOutput("midrst_valid", 32'(valid_out), 32'd1);
    checkOutput("midrst_read_enb", 32'(read_enb), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    flush = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    check_reset_values("midrst");
    checkOutput("midrst_nodone", 32'(done_cnt - d0), 32'd0);
    run_packet(8'h05, 1'b0, 1'b1, "afterrst");

    // Counter wrap over 256 good len-0 packets
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      run_packet(8'h01, 1'b0, 1'b0, "wrap");
      if (i == 254) checkOutput("wrap_255", 32'(pkt_count), cnt_model(exp_pkt));
    end
    checkOutput("wrap_pktcnt", 32'(pkt_count), cnt_model(exp_pkt));
    checkOutput("wrap_errcnt", 32'(err_count), cnt_model(exp_err));

    hdr_len = 0;
    checkOutput("read_only_when_valid", 32'(bad_rd), 32'(hdr_len));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
